// File: rtl/pdetect_stream_match.sv
// Stream pass-through with a 2-entry skid buffer and a masked pattern detector
// watching accepted input beats; counts matches with a saturating counter.
module pdetect_stream_match #(
  parameter int                           DATA_W  = 8,
  parameter int                           PAT_LEN = 4,
  parameter logic [DATA_W*PAT_LEN-1:0]    PATTERN = 32'h0A0B0C0D,
  parameter logic [DATA_W*PAT_LEN-1:0]    MASK    = '1,
  parameter bit                           OVERLAP = 1'b1,
  parameter int                           CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_m_data,
  input  logic              i_m_valid,
  output logic              o_m_ready,
  output logic [DATA_W-1:0] o_s_data,
  output logic              o_s_valid,
  input  logic              i_s_ready,
  input  logic              i_cnt_clr,
  output logic              o_detected,
  output logic [CNT_W-1:0]  o_match_cnt
);

  localparam int HIST_W = DATA_W * PAT_LEN;
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

  // Handshake: a beat transfers on a rising edge only when valid && ready are
  // both high; valid never waits on ready, and ready is a flop so the
  // downstream ready never reaches the upstream ready combinationally.
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]        count_q, count_d, count_after_pop;
  logic              ready_q, ready_d;
  logic              push, pop;

  logic [HIST_W-1:0] hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              match;
  logic              detected_q, detected_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    push            = i_m_valid && ready_q;
    pop             = (count_q != 2'd0) && i_s_ready;
    buf0_d          = buf0_q;
    buf1_d          = buf1_q;
    count_after_pop = count_q - {1'b0, pop};
    if (pop) begin
      buf0_d = buf1_q;
    end
    // ready_q low whenever two entries are held, so push never meets a full buffer
    if (push) begin
      if (count_after_pop == 2'd0) begin
        buf0_d = i_m_data;
      end else begin
        buf1_d = i_m_data;
      end
    end
    count_d = count_after_pop + {1'b0, push};
    ready_d = (count_d != 2'd2);
  end

  always_comb begin
    hist_shift = {hist_q[HIST_W-DATA_W-1:0], i_m_data};
    fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    match      = push && (fill_inc == FILL_MAX) &&
                 (((hist_shift ^ PATTERN) & MASK) == '0);
    hist_d     = hist_q;
    fill_d     = fill_q;
    if (push) begin
      hist_d = hist_shift;
      fill_d = (match && (OVERLAP == 1'b0)) ? '0 : fill_inc;
    end
    detected_d = match;
    cnt_d      = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      count_q    <= 2'd0;
      ready_q    <= 1'b0;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      detected_q <= detected_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_m_ready   = ready_q;
  assign o_s_data    = buf0_q;
  assign o_s_valid   = (count_q != 2'd0);
  assign o_detected  = detected_q;
  assign o_match_cnt = cnt_q;

endmodule

// File: tb/tb_pdetect_stream_match.sv
// Directed bench: five parameter variants share one input stream; stream data
// is scoreboarded on the default instance, detection/counts checked per step.
module tb_pdetect_stream_match;

  logic       clk;
  logic       rst_n;
  logic [7:0] m_data;
  logic       m_valid;
  logic       s_ready;
  logic       cnt_clr;

  // index 0 default, 1 overlap pattern OVERLAP=1, 2 same OVERLAP=0, 3 masked, 4 CNT_W=2
  logic [4:0]  rdy;
  logic [4:0]  sv;
  logic [4:0]  det;
  logic [7:0]  sd [5];
  logic [15:0] cnt [4];
  logic [1:0]  cnt_c2;

  localparam logic [4:0] NONE     = 5'b00000;
  localparam logic [4:0] DEF_HIT  = 5'b11001;
  localparam logic [4:0] MSK_HIT  = 5'b01000;
  localparam logic [4:0] OV_BOTH  = 5'b00110;
  localparam logic [4:0] OV1_ONLY = 5'b00010;

  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  pdetect_stream_match u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_data(m_data), .i_m_valid(m_valid),
    .o_m_ready(rdy[0]), .o_s_data(sd[0]), .o_s_valid(sv[0]), .i_s_ready(s_ready),
    .i_cnt_clr(cnt_clr), .o_detected(det[0]), .o_match_cnt(cnt[0]));

  pdetect_stream_match #(.PATTERN(32'h0A0B0A0B), .OVERLAP(1'b1)) u_ov1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_data(m_data), .i_m_valid(m_valid),
    .o_m_ready(rdy[1]), .o_s_data(sd[1]), .o_s_valid(sv[1]), .i_s_ready(s_ready),
    .i_cnt_clr(cnt_clr), .o_detected(det[1]), .o_match_cnt(cnt[1]));

  pdetect_stream_match #(.PATTERN(32'h0A0B0A0B), .OVERLAP(1'b0)) u_ov0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_data(m_data), .i_m_valid(m_valid),
    .o_m_ready(rdy[2]), .o_s_data(sd[2]), .o_s_valid(sv[2]), .i_s_ready(s_ready),
    .i_cnt_clr(cnt_clr), .o_detected(det[2]), .o_match_cnt(cnt[2]));

  pdetect_stream_match #(.PATTERN(32'h0A0B0C00), .MASK(32'hFFFFFF00)) u_msk (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_data(m_data), .i_m_valid(m_valid),
    .o_m_ready(rdy[3]), .o_s_data(sd[3]), .o_s_valid(sv[3]), .i_s_ready(s_ready),
    .i_cnt_clr(cnt_clr), .o_detected(det[3]), .o_match_cnt(cnt[3]));

  pdetect_stream_match #(.CNT_W(2)) u_c2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_data(m_data), .i_m_valid(m_valid),
    .o_m_ready(rdy[4]), .o_s_data(sd[4]), .o_s_valid(sv[4]), .i_s_ready(s_ready),
    .i_cnt_clr(cnt_clr), .o_detected(det[4]), .o_match_cnt(cnt_c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cycle with o_s_valid the head must equal the oldest
  // expected beat (also proves stability under backpressure); pop on transfer.
  always @(negedge clk) begin
    if (rst_n && sv[0]) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", exp_q.size(), 1);
      end else begin
        chk("s_data", {24'h0, sd[0]}, {24'h0, exp_q[0]});
        if (s_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [4:0] exp_det);
    int budget;
    budget  = 0;
    m_data  = d;
    m_valid = 1'b1;
    while (!rdy[0] && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!rdy[0]) begin
      chk("ready_timeout", {31'h0, rdy[0]}, 1);
      m_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(d);
    #1;
    m_valid = 1'b0;
    chk("detected", {27'h0, det}, {27'h0, exp_det});
  endtask

  task automatic chk_cnt(input int c0, input int c1, input int c2, input int c3, input int c4);
    chk("cnt_def", {16'h0, cnt[0]}, c0);
    chk("cnt_ov1", {16'h0, cnt[1]}, c1);
    chk("cnt_ov0", {16'h0, cnt[2]}, c2);
    chk("cnt_msk", {16'h0, cnt[3]}, c3);
    chk("cnt_c2", {30'h0, cnt_c2}, c4);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_ready", {27'h0, rdy}, 0);
    chk("rst_valid", {27'h0, sv}, 0);
    chk("rst_data", {24'h0, sd[0]}, 0);
    chk("rst_det", {27'h0, det}, 0);
    chk("rst_cnt", {16'h0, cnt[0]}, 0);
    chk("rst_cnt_c2", {30'h0, cnt_c2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", {27'h0, rdy}, 0);
    @(posedge clk); #1;
    chk("ready_post_edge", {27'h0, rdy}, 5'b11111);
  endtask

  initial begin
    rst_n   = 1'b0;
    m_data  = 8'h00;
    m_valid = 1'b0;
    s_ready = 1'b1;
    cnt_clr = 1'b0;

    // basic match, back-to-back, then pulse must drop
    do_reset();
    send(8'h0A, NONE); send(8'h0B, NONE); send(8'h0C, NONE); send(8'h0D, DEF_HIT);
    @(posedge clk); #1;
    chk("det_one_cycle", {27'h0, det}, 0);
    chk_cnt(1, 0, 0, 1, 1);
    drain();

    // near-miss prefix followed by the real pattern
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h0A, NONE);
    send(8'h0A, NONE); send(8'h0B, NONE); send(8'h0C, NONE); send(8'h0D, DEF_HIT);
    chk_cnt(1, 0, 0, 1, 1);
    drain();

    // overlapping vs flushed history, with idle gaps between beats
    do_reset();
    send(8'h0A, NONE); send(8'h0B, NONE);
    repeat (3) @(posedge clk);
    #1;
    send(8'h0A, NONE); send(8'h0B, OV_BOTH);
    send(8'h0A, NONE);
    @(posedge clk); #1;
    send(8'h0B, OV1_ONLY);
    chk_cnt(0, 2, 1, 0, 0);
    drain();

    // masked compare: last symbol is don't-care, third must still match
    do_reset();
    send(8'h0A, NONE); send(8'h0B, NONE); send(8'h0C, NONE); send(8'h77, MSK_HIT);
    send(8'h0A, NONE); send(8'h0B, NONE); send(8'h0D, NONE); send(8'h77, NONE);
    chk_cnt(0, 0, 0, 1, 0);
    drain();

    // backpressure: buffer fills after two beats, then releases in order
    do_reset();
    s_ready = 1'b0;
    send(8'h0A, NONE); send(8'h0B, NONE);
    chk("ready_full", {27'h0, rdy}, 0);
    m_data  = 8'h0C;
    m_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("ready_held", {27'h0, rdy}, 0);
    end
    s_ready = 1'b1;
    send(8'h0C, NONE); send(8'h0D, DEF_HIT);
    chk_cnt(1, 0, 0, 1, 1);
    drain();

    // counter saturation, clear, clear coincident with a match
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'h0A, NONE); send(8'h0B, NONE); send(8'h0C, NONE); send(8'h0D, DEF_HIT);
    end
    chk_cnt(5, 0, 0, 5, 3);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk_cnt(0, 0, 0, 0, 0);
    send(8'h0A, NONE); send(8'h0B, NONE); send(8'h0C, NONE);
    cnt_clr = 1'b1;
    send(8'h0D, DEF_HIT);
    cnt_clr = 1'b0;
    chk_cnt(1, 0, 0, 1, 1);
    drain();

    // reset mid-pattern discards partial history
    send(8'h0A, NONE); send(8'h0B, NONE);
    do_reset();
    send(8'h0C, NONE); send(8'h0D, NONE);
    chk_cnt(0, 0, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pdetect_stream_match.md
PDETECT_STREAM_MATCH -- requirements
Module: pdetect_stream_match

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DATA_W, 8, stream symbol width in bits.
- PAT_LEN, 4, pattern length in symbols (2..16).
- PATTERN, 32'h0A0B0C0D, DATA_W*PAT_LEN bits; first beat = most-significant symbol.
- MASK, all ones, DATA_W*PAT_LEN bits; 1 = compare bit, 0 = don't care.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history flushed after each match.
- CNT_W, 16, match counter width.
REQ-002 Ports, one per line: name, direction, width, meaning:
- i_clk, in, 1, single clock, all logic on rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_m_data, in, DATA_W, upstream symbol.
- i_m_valid, in, 1, upstream valid.
- o_m_ready, out, 1, ready to upstream.
- o_s_data, out, DATA_W, downstream symbol.
- o_s_valid, out, 1, downstream valid.
- i_s_ready, in, 1, downstream ready.
- i_cnt_clr, in, 1, synchronous match-counter clear.
- o_detected, out, 1, one-cycle match pulse.
- o_match_cnt, out, CNT_W, saturating match count.

Function
REQ-003 Input beat accepted on rising edge when i_m_valid && o_m_ready; output beat consumed when o_s_valid && i_s_ready.
REQ-004 Stream path: 2-entry skid buffer; o_m_ready registered, equal to "buffer not full"; no combinational path from i_s_ready to o_m_ready.
REQ-005 Latency: accepted beat appears on o_s_data/o_s_valid the cycle after acceptance when buffer was empty; order preserved, no loss or duplication.
REQ-006 Full throughput: with i_s_ready held 1, one beat per cycle sustained indefinitely.
REQ-007 o_s_data/o_s_valid held stable while o_s_valid && !i_s_ready.
REQ-008 History: shift register of last PAT_LEN accepted symbols plus fill counter 0..PAT_LEN saturating; updated only on accepted beats.
REQ-009 Match condition: fill counter == PAT_LEN after including the current beat, and ((history ^ PATTERN) & MASK) == 0.
REQ-010 o_detected asserts the cycle after the accepting edge of the final matching beat, for exactly one cycle; stays 0 on non-accepting cycles.
REQ-011 OVERLAP=0: on match, fill counter returns to 0, so the next match needs PAT_LEN new beats.
REQ-012 OVERLAP=1: fill counter unchanged on match; shared suffix/prefix symbols count toward the next match.
REQ-013 Detection depends only on the input side; downstream backpressure affects it only through o_m_ready.
REQ-014 o_match_cnt increments by 1 per match and saturates at 2^CNT_W-1, with no wrap.
REQ-015 i_cnt_clr high: counter becomes 0; if a match occurs in the same cycle, counter becomes 1.
REQ-016 Gaps (i_m_valid low) between pattern beats do not break a match.

Reset
REQ-017 i_rst_n low asynchronously forces o_m_ready=0, o_s_valid=0, o_s_data=0, o_detected=0, o_match_cnt=0, fill counter=0, buffer empty.
REQ-018 o_m_ready rises on the first rising edge after i_rst_n deasserts.
REQ-019 Reset mid-pattern or mid-stream discards partial history and buffered beats; the first match after reset needs PAT_LEN new beats.

Verification
REQ-020 Defaults, beats 0A,0B,0C,0D back-to-back, i_s_ready=1 -> o_detected=1 one cycle after the 0D edge, 0 the next cycle; o_match_cnt=1; o_s_data shows 0A..0D, each 1 cycle later.
REQ-021 Defaults, beats 0A,0A,0A,0A, then 0A,0B,0C,0D -> no pulse on the first group; one pulse after the second 0D; o_match_cnt=1.
REQ-022 PATTERN=32'h0A0B0A0B, beats 0A,0B,0A,0B,0A,0B -> OVERLAP=1: pulses after beats 4 and 6, count=2; OVERLAP=0: pulse after beat 4 only, count=1.
REQ-023 MASK=32'hFFFFFF00, PATTERN=32'h0A0B0C00, beats 0A,0B,0C,77 -> o_detected=1; beats 0A,0B,0D,77 -> no pulse.
REQ-024 Continuous input with i_s_ready=0 for 3 cycles -> o_m_ready=0 after 2 buffered beats; after release, all beats out in order with none lost; detection still fires on 0A,0B,0C,0D.
REQ-025 CNT_W=2: 5 matches -> o_match_cnt=3 (saturated); i_cnt_clr pulsed alone -> 0; i_cnt_clr coincident with a match -> 1; i_rst_n pulsed low after 0A,0B, then 0C,0D -> no pulse.
